// File: rtl/sobel_edge_filter.sv
// sobel_edge_filter: RGB444 to grayscale, 3x3 Sobel |Gx|+|Gy| magnitude, scaled and saturated to 4 bits,
// emitted as gray RGB444 through a fixed 3-stage pipeline with valid/frame tags.
module sobel_edge_filter #(
  parameter int DATA_WIDTH  = 12,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int SCALE_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] row0_pixel,
  input  logic [DATA_WIDTH-1:0] row1_pixel,
  input  logic [DATA_WIDTH-1:0] row2_pixel,
  input  logic                  in_edge,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_pixel,
  output logic                  out_edge,
  output logic                  out_valid
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  function automatic logic [5:0] gray(input logic [DATA_WIDTH-1:0] p);
    return {2'b0, p[11:8]} + {1'b0, p[7:4], 1'b0} + {2'b0, p[3:0]};
  endfunction

  logic [5:0] tl, tc, tr, ml, mc, mr, bl, bc, br;
  logic [CW-1:0] col, col_nxt;
  logic [RW-1:0] row, row_nxt;
  logic wrap, border;
  logic v1, b1, e1, v2, b2, e2;
  logic [7:0] sx_p, sx_n, sy_p, sy_n;
  logic signed [8:0] gx, gy;
  logic [8:0] ax, ay, mag, sh;
  logic [3:0] s;

  assign wrap    = col == CW'(IMG_WIDTH - 1);
  assign col_nxt = in_edge ? CW'(1) : wrap ? '0 : col + CW'(1);
  assign row_nxt = in_edge ? '0 : !wrap ? row : (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + RW'(1);
  // position of the pixel being accepted, before the counters advance
  assign border  = in_edge | (col < CW'(2)) | (row < RW'(2));

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {tl, tc, tr, ml, mc, mr, bl, bc, br} <= '0;
      col <= '0;
      row <= '0;
      v1  <= 1'b0;
      b1  <= 1'b0;
      e1  <= 1'b0;
    end else begin
      v1 <= in_valid;
      b1 <= border;
      e1 <= in_edge & in_valid;
      if (in_valid) begin
        {tl, tc, tr} <= {tc, tr, gray(row2_pixel)};
        {ml, mc, mr} <= {mc, mr, gray(row1_pixel)};
        {bl, bc, br} <= {bc, br, gray(row0_pixel)};
        col <= col_nxt;
        row <= row_nxt;
      end
    end

  assign sx_p = {2'b0, tr} + {1'b0, mr, 1'b0} + {2'b0, br};
  assign sx_n = {2'b0, tl} + {1'b0, ml, 1'b0} + {2'b0, bl};
  assign sy_p = {2'b0, bl} + {1'b0, bc, 1'b0} + {2'b0, br};
  assign sy_n = {2'b0, tl} + {1'b0, tc, 1'b0} + {2'b0, tr};

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      gx <= '0;
      gy <= '0;
      v2 <= 1'b0;
      b2 <= 1'b0;
      e2 <= 1'b0;
    end else begin
      gx <= $signed({1'b0, sx_p}) - $signed({1'b0, sx_n});
      gy <= $signed({1'b0, sy_p}) - $signed({1'b0, sy_n});
      v2 <= v1;
      b2 <= b1;
      e2 <= e1;
    end

  assign ax  = gx[8] ? 9'(-gx) : 9'(gx);
  assign ay  = gy[8] ? 9'(-gy) : 9'(gy);
  assign mag = ax + ay;
  assign sh  = mag >> SCALE_SHIFT;
  assign s   = (sh > 9'd15) ? 4'hF : sh[3:0];

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_pixel <= '0;
      out_edge  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        out_pixel <= b2 ? '0 : {s, s, s};
        out_edge  <= e2;
      end
    end
endmodule

// File: tb/tb_sobel_edge_filter.sv
// tb_sobel_edge_filter: directed scenarios with hand-computed Sobel results; each input is labelled
// row*1000+col so a result can be matched to the pixel that produced it three clocks earlier.
module tb_sobel_edge_filter;
  logic clk = 1'b0, rst = 1'b0;
  logic [11:0] row0_pixel = '0, row1_pixel = '0, row2_pixel = '0;
  logic in_edge = 1'b0, in_valid = 1'b0;
  logic [11:0] out_pixel;
  logic out_edge, out_valid;
  int pass_n = 0, total_n = 0;
  int lab[3] = '{-1, -1, -1};

  sobel_edge_filter dut (
    .clk(clk), .rst(rst), .row0_pixel(row0_pixel), .row1_pixel(row1_pixel), .row2_pixel(row2_pixel),
    .in_edge(in_edge), .in_valid(in_valid), .out_pixel(out_pixel), .out_edge(out_edge), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] px(input int kind, input int t, input int c);
    return kind == 0 ? 12'h888 : kind == 1 ? (c < 8 ? 12'h000 : 12'hFFF) :
           kind == 2 ? (c < 8 ? 12'h000 : 12'h111) : (t == 0 ? 12'hFFF : 12'h000);
  endfunction

  // after a tick, lab[2] names the input whose result is on the outputs
  task automatic tick(input logic [11:0] a0, a1, a2, input logic e, v, input int l);
    row0_pixel = a0; row1_pixel = a1; row2_pixel = a2; in_edge = e; in_valid = v;
    @(posedge clk); #1;
    lab[2] = lab[1]; lab[1] = lab[0]; lab[0] = v ? l : -1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total_n++; if (out_pixel !== 12'h000) $display("FAIL reset_pixel got %h want 000", out_pixel); else pass_n++;
    total_n++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_n++;
    total_n++; if (out_edge !== 1'b0) $display("FAIL reset_edge got %b want 0", out_edge); else pass_n++;
    rst = 1'b1;
  endtask

  task automatic test_uniform;
    int nv = 0, ne = 0, nz = 0, bad_v = 0;
    for (int i = 0; i < 1923; i++) begin
      automatic int r = i / 640, c = i % 640;
      tick(px(0, 0, c), px(0, 1, c), px(0, 2, c), i == 0, i < 1920, r * 1000 + c);
      if (out_valid !== (lab[2] >= 0)) bad_v++;
      if (out_valid) begin
        nv++;
        if (out_edge) ne++;
        if (out_pixel != 12'h000) nz++;
      end
      if (lab[2] == 0) begin
        total_n++; if (out_edge !== 1'b1) $display("FAIL uniform_edge_pos got %b want 1", out_edge); else pass_n++;
      end
    end
    total_n++; if (nv != 1920) $display("FAIL uniform_valid_count got %0d want 1920", nv); else pass_n++;
    total_n++; if (ne != 1) $display("FAIL uniform_edge_count got %0d want 1", ne); else pass_n++;
    total_n++; if (nz != 0) $display("FAIL uniform_nonzero got %0d want 0", nz); else pass_n++;
    total_n++; if (bad_v != 0) $display("FAIL uniform_valid_align got %0d want 0", bad_v); else pass_n++;
  endtask

  task automatic test_vstep(input int kind, input logic [11:0] want);
    for (int i = 0; i < 1923; i++) begin
      automatic int r = i / 640, c = i % 640;
      tick(px(kind, 0, c), px(kind, 1, c), px(kind, 2, c), i == 0, i < 1920, r * 1000 + c);
      if (lab[2] == 1009) begin
        total_n++; if (out_pixel !== 12'h000) $display("FAIL vstep%0d_row1 got %h want 000", kind, out_pixel); else pass_n++;
      end
      if (lab[2] == 2009) begin
        total_n++; if (out_pixel !== want) $display("FAIL vstep%0d_c9 got %h want %h", kind, out_pixel, want); else pass_n++;
      end
      if (lab[2] == 2011) begin
        total_n++; if (out_pixel !== 12'h000) $display("FAIL vstep%0d_c11 got %h want 000", kind, out_pixel); else pass_n++;
      end
    end
  endtask

  task automatic test_hstep;
    for (int i = 0; i < 1923; i++) begin
      automatic int r = i / 640, c = i % 640;
      tick(px(3, 0, c), px(3, 1, c), px(3, 2, c), i == 0, i < 1920, r * 1000 + c);
      if (lab[2] == 2000 || lab[2] == 2001 || lab[2] == 1005) begin
        total_n++; if (out_pixel !== 12'h000) $display("FAIL hstep_border_%0d got %h want 000", lab[2], out_pixel); else pass_n++;
      end
      if (lab[2] == 2005 || lab[2] == 2639) begin
        total_n++; if (out_pixel !== 12'hFFF) $display("FAIL hstep_%0d got %h want fff", lab[2], out_pixel); else pass_n++;
      end
    end
  endtask

  task automatic test_gaps;
    int bad_v = 0, spur = 0;
    for (int i = 0; i < 1923; i++) begin
      automatic int r = i / 640, c = i % 640;
      for (int k = 0; k < ((c % 2 == 1 && i < 1920) ? 3 : 1); k++) begin
        if (k == 0) tick(px(1, 0, c), px(1, 1, c), px(1, 2, c), i == 0, i < 1920, r * 1000 + c);
        else tick(12'h5A3, 12'h5A3, 12'h5A3, 1'b1, 1'b0, -1);
        if (out_valid !== (lab[2] >= 0)) bad_v++;
        if (out_valid && out_edge && lab[2] != 0) spur++;
        if (lab[2] == 0) begin
          total_n++; if (out_edge !== 1'b1) $display("FAIL gaps_edge_pos got %b want 1", out_edge); else pass_n++;
        end
        if (lab[2] == 2009) begin
          total_n++; if (out_pixel !== 12'hFFF) $display("FAIL gaps_c9 got %h want fff", out_pixel); else pass_n++;
        end
        if (lab[2] == 2011) begin
          total_n++; if (out_pixel !== 12'h000) $display("FAIL gaps_c11 got %h want 000", out_pixel); else pass_n++;
        end
      end
    end
    total_n++; if (bad_v != 0) $display("FAIL gaps_valid_align got %0d want 0", bad_v); else pass_n++;
    total_n++; if (spur != 0) $display("FAIL gaps_spurious_edge got %0d want 0", spur); else pass_n++;
  endtask

  task automatic test_reset_mid;
    int stray = 0;
    for (int i = 0; i <= 1380; i++) begin
      automatic int r = i / 640, c = i % 640;
      tick(px(3, 0, c), px(3, 1, c), px(3, 2, c), i == 0, 1'b1, r * 1000 + c);
    end
    total_n++;
    if (out_valid !== 1'b1 || out_pixel !== 12'hFFF) $display("FAIL mid_pre got v=%b %h want v=1 fff", out_valid, out_pixel);
    else pass_n++;
    #1 rst = 1'b0;
    #1;
    total_n++; if (out_pixel !== 12'h000) $display("FAIL mid_rst_pixel got %h want 000", out_pixel); else pass_n++;
    total_n++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", out_valid); else pass_n++;
    total_n++; if (out_edge !== 1'b0) $display("FAIL mid_rst_edge got %b want 0", out_edge); else pass_n++;
    @(posedge clk); #1;
    rst = 1'b1;
    lab = '{-1, -1, -1};
    for (int k = 0; k < 3; k++) begin
      tick(12'h000, 12'h000, 12'h000, 1'b0, 1'b0, -1);
      if (out_valid !== 1'b0) stray++;
    end
    total_n++; if (stray != 0) $display("FAIL mid_flushed got %0d want 0", stray); else pass_n++;
    for (int c = 0; c < 5; c++) begin
      tick(px(3, 0, c), px(3, 1, c), px(3, 2, c), c == 0, 1'b1, c);
      if (lab[2] == 0) begin
        total_n++; if (out_valid !== 1'b1) $display("FAIL post_valid got %b want 1", out_valid); else pass_n++;
        total_n++; if (out_edge !== 1'b1) $display("FAIL post_edge got %b want 1", out_edge); else pass_n++;
        total_n++; if (out_pixel !== 12'h000) $display("FAIL post_border got %h want 000", out_pixel); else pass_n++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_uniform;
    test_vstep(1, 12'hFFF);
    test_vstep(2, 12'h222);
    test_hstep;
    test_gaps;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
